// File: rtl/util_cpack_ts_pkg.sv
// Shared types and constants for the timestamp-framing channel packer.
// Header words carry the 64-bit frame timestamp zero-extended to the packed word width.
package util_cpack_ts_pkg;

    localparam int TS_WIDTH      = 64;
    localparam int EVERY_WIDTH   = 32;
    localparam int OVF_CNT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    function automatic logic [OVF_CNT_WIDTH-1:0] sat_inc16(input logic [OVF_CNT_WIDTH-1:0] v);
        return (v == {OVF_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/util_cpack_ts_compact.sv
// Channel compaction: enabled channels are packed towards the LSBs in ascending channel order,
// and the number of enabled channels is reported alongside.
module util_cpack_ts_compact #(
    parameter int NUM  = 4,
    parameter int CH_W = 16,
    parameter int E_W  = 3
) (
    input  logic [NUM-1:0]      enable_i,
    input  logic [NUM*CH_W-1:0] data_i,
    output logic [NUM*CH_W-1:0] data_o,
    output logic [E_W-1:0]      count_o
);

    always_comb begin
        int idx;
        idx     = 0;
        data_o  = '0;
        for (int c = 0; c < NUM; c++) begin
            if (enable_i[c]) begin
                data_o[idx*CH_W +: CH_W] = data_i[c*CH_W +: CH_W];
                idx = idx + 1;
            end
        end
        count_o = E_W'(idx);
    end

endmodule

// File: rtl/util_cpack_ts_framer.sv
// Packs enabled channel samples into wide words and frames every N beats behind a timestamp
// header; words leave through a small queue so a beat that cannot fit is dropped whole.
module util_cpack_ts_framer
    import util_cpack_ts_pkg::*;
#(
    parameter int NUM_OF_CHANNELS     = 4,
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int OUT_WIDTH           = 64,
    parameter int QUEUE_DEPTH         = 4
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [63:0]                                                  timestamp,
    input  logic [31:0]                                                  timestamp_every,
    input  logic [NUM_OF_CHANNELS-1:0]                                   enable,
    input  logic                                                         fifo_wr_en,
    input  logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                                                         fifo_wr_overflow,
    output logic                                                         packed_fifo_wr_en,
    input  logic                                                         packed_fifo_wr_overflow,
    output logic                                                         packed_fifo_wr_sync,
    output logic [OUT_WIDTH-1:0]                                         packed_fifo_wr_data,
    output logic [15:0]                                                  overflow_count
);

    localparam int CH_W   = SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;
    localparam int IN_W   = NUM_OF_CHANNELS * CH_W;
    localparam int ACC_W  = 2 * OUT_WIDTH;
    localparam int BITS_W = $clog2(ACC_W + 1);
    localparam int E_W    = $clog2(NUM_OF_CHANNELS + 1);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = OUT_WIDTH + 1;

    if (NUM_OF_CHANNELS < 1 || NUM_OF_CHANNELS > 16) begin : g_bad_num
        $error("NUM_OF_CHANNELS must be 1..16");
    end
    if (OUT_WIDTH < TS_WIDTH || (OUT_WIDTH % SAMPLE_DATA_WIDTH) != 0 || IN_W > OUT_WIDTH) begin : g_bad_width
        $error("illegal OUT_WIDTH / sample geometry");
    end
    if (QUEUE_DEPTH < 2 || (1 << PTR_W) != QUEUE_DEPTH) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of 2, >= 2");
    end

    logic [IN_W-1:0] compact;
    logic [E_W-1:0]  e_count;

    frame_state_e       state_q, state_d;
    logic [NUM_OF_CHANNELS-1:0] en_q;
    logic [31:0]        f_q, f_d, beat_cnt_q, beat_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BITS_W-1:0]  acc_bits_q, acc_bits_d;
    logic               sync_pend_q, sync_pend_d;
    logic [15:0]        ovf_cnt_q, ovf_cnt_d;
    logic               drop_q, drop_d;
    logic [ENT_W-1:0]   mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               out_en_q, out_sync_q;
    logic [OUT_WIDTH-1:0] out_data_q;

    logic               en_changed, starting, full, last, flush, hdr, dsync;
    logic               beat_ok, accept, drop, deq;
    logic [BITS_W-1:0]  beat_bits, tot, rem;
    logic [31:0]        f_eff, cnt_eff;
    logic [ACC_W-1:0]   merged;
    logic [1:0]         needed, n_enq;
    logic [CNT_W-1:0]   free_slots;
    logic [ENT_W-1:0]   hdr_word, d0, d1, enq0, enq1;

    util_cpack_ts_compact #(
        .NUM  (NUM_OF_CHANNELS),
        .CH_W (CH_W),
        .E_W  (E_W)
    ) u_compact (
        .enable_i (en_q),
        .data_i   (fifo_wr_data),
        .data_o   (compact),
        .count_o  (e_count)
    );

    // The frame's final beat may complete one word and leave a remainder, so it can emit two
    // data words; it never carries a header unless the frame is a single beat long.
    always_comb begin
        en_changed = (enable != en_q);
        beat_bits  = BITS_W'(e_count) * BITS_W'(CH_W);
        starting   = (state_q == ST_IDLE);
        f_eff      = starting ? timestamp_every : f_q;
        cnt_eff    = starting ? 32'd1 : beat_cnt_q + 32'd1;
        merged     = acc_q | (ACC_W'(compact) << acc_bits_q);
        tot        = acc_bits_q + beat_bits;
        full       = (tot >= BITS_W'(OUT_WIDTH));
        rem        = full ? tot - BITS_W'(OUT_WIDTH) : tot;
        last       = (f_eff != 32'd0) && (cnt_eff == f_eff);
        flush      = last && (rem != '0);
        hdr        = starting && (timestamp_every != 32'd0);
        dsync      = starting ? (timestamp_every == 32'd0) : sync_pend_q;
        needed     = 2'(hdr) + 2'(full | flush) + 2'(full & flush);
        free_slots = CNT_W'(QUEUE_DEPTH) - count_q;
        beat_ok    = fifo_wr_en && !packed_fifo_wr_overflow && !en_changed && (e_count != '0);
        accept     = beat_ok && (free_slots >= CNT_W'(needed));
        drop       = beat_ok && !accept;
        hdr_word   = {1'b1, OUT_WIDTH'(timestamp)};
        d0         = {dsync, merged[OUT_WIDTH-1:0]};
        d1         = {1'b0, merged[ACC_W-1:OUT_WIDTH]};
        enq0       = hdr ? hdr_word : d0;
        enq1       = hdr ? d0 : d1;
        n_enq      = accept ? needed : 2'd0;
        deq        = (count_q != '0);

        state_d     = state_q;
        f_d         = f_q;
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        acc_bits_d  = acc_bits_q;
        sync_pend_d = sync_pend_q;
        ovf_cnt_d   = ovf_cnt_q;
        drop_d      = 1'b0;

        if (packed_fifo_wr_overflow || en_changed || drop) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            acc_bits_d  = '0;
            sync_pend_d = 1'b0;
            drop_d      = drop;
            if (packed_fifo_wr_overflow) begin
                ovf_cnt_d = sat_inc16(ovf_cnt_q);
            end
        end else if (accept) begin
            if (last) begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                acc_bits_d  = '0;
                sync_pend_d = 1'b0;
            end else begin
                state_d     = ST_ACTIVE;
                f_d         = f_eff;
                beat_cnt_d  = cnt_eff;
                acc_d       = full ? (merged >> OUT_WIDTH) : merged;
                acc_bits_d  = rem;
                sync_pend_d = dsync && !full;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            en_q        <= '0;
            f_q         <= '0;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            acc_bits_q  <= '0;
            sync_pend_q <= 1'b0;
            ovf_cnt_q   <= '0;
            drop_q      <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_en_q    <= 1'b0;
            out_sync_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= enable;
            f_q         <= f_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            acc_bits_q  <= acc_bits_d;
            sync_pend_q <= sync_pend_d;
            ovf_cnt_q   <= ovf_cnt_d;
            drop_q      <= drop_d;
            if (n_enq != 2'd0) begin
                mem_q[wr_ptr_q] <= enq0;
            end
            if (n_enq == 2'd2) begin
                mem_q[PTR_W'(wr_ptr_q + 1'b1)] <= enq1;
            end
            wr_ptr_q    <= wr_ptr_q + PTR_W'(n_enq);
            count_q     <= count_q + CNT_W'(n_enq) - CNT_W'(deq);
            out_en_q    <= deq;
            if (deq) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                out_sync_q <= mem_q[rd_ptr_q][OUT_WIDTH];
                out_data_q <= mem_q[rd_ptr_q][OUT_WIDTH-1:0];
            end else begin
                out_sync_q <= 1'b0;
                out_data_q <= '0;
            end
        end
    end

    assign fifo_wr_overflow    = drop_q;
    assign packed_fifo_wr_en   = out_en_q;
    assign packed_fifo_wr_sync = out_sync_q;
    assign packed_fifo_wr_data = out_data_q;
    assign overflow_count      = ovf_cnt_q;

endmodule
